// File: rtl/frog_move_sequencer_if.sv
// Move handshake between the frog move sequencer and the frog motion logic.
// The sequencer drives the master side; the consumer drives the slave side.
interface frog_move_sequencer_if;
    logic       move_valid;
    logic       move_ready;
    logic [1:0] move_dir;

    modport master (
        output move_valid,
        output move_dir,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        output move_ready
    );
endinterface

// File: rtl/frog_move_sequencer.sv
// Frog move sequencer: turns the NIOS keycode export into frame-aligned frog
// moves, queued in a small FIFO and handed out with valid/ready.
// Optional feature macro: FROG_AUTOREPEAT_EN (hold-to-repeat moves). When it is
// undefined, a held key produces exactly one move per press or direction change.
module frog_move_sequencer #(
    parameter int       FIFO_DEPTH    = 4,
    parameter int       REPEAT_DELAY  = 15,
    parameter int       REPEAT_PERIOD = 6,
    parameter bit [7:0] KEY_UP        = 8'h1A,
    parameter bit [7:0] KEY_LEFT      = 8'h04,
    parameter bit [7:0] KEY_DOWN      = 8'h16,
    parameter bit [7:0] KEY_RIGHT     = 8'h07
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_clk,
    input  logic [15:0]                 keycode,
    frog_move_sequencer_if.master       move,
    output logic [$clog2(FIFO_DEPTH):0] queue_count,
    output logic                        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Reject configurations the FIFO pointers and 8-bit frame counter cannot honour.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_param_check
        $error("frog_move_sequencer: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Frame tick: two-flop synchroniser plus one edge-detect flop
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, sync3_q;
    logic frame_tick;

    // Synchronise VGA_VS into the Clk domain and keep the previous level.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign frame_tick = sync2_q & ~sync3_q;

    // ------------------------------------------------------------------
    // Key decode: only the low byte carries the HID usage code
    // ------------------------------------------------------------------
    logic       hit;
    logic [1:0] key_dir;
    logic       unused_key_hi;

    assign unused_key_hi = ^keycode[15:8];

    // Map the four WASD codes onto a direction; everything else is no key.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        hit     = 1'b1;
        key_dir = 2'd0;
        case (keycode[7:0])
            KEY_UP:    key_dir = 2'd0;
            KEY_LEFT:  key_dir = 2'd1;
            KEY_DOWN:  key_dir = 2'd2;
            KEY_RIGHT: key_dir = 2'd3;
            default:   hit     = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Move FSM, advanced once per frame tick
    // ------------------------------------------------------------------
`ifdef FROG_AUTOREPEAT_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

    localparam logic [7:0] DELAY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

    logic [7:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic       push;
    logic [1:0] push_dir;

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cur_dir_q <= 2'd0;
`ifdef FROG_AUTOREPEAT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
`ifdef FROG_AUTOREPEAT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and move-push decision; nothing happens between ticks.
    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        push      = 1'b0;
        push_dir  = cur_dir_q;
`ifdef FROG_AUTOREPEAT_EN
        cnt_d     = cnt_q;
`endif
        if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        push      = 1'b1;
                        push_dir  = key_dir;
                        cur_dir_d = key_dir;
                        state_d   = S_HOLD;
`ifdef FROG_AUTOREPEAT_EN
                        cnt_d     = 8'd0;
`endif
                    end
                end
                S_HOLD: begin
                    if (!hit) begin
                        state_d = S_IDLE;
                    end else if (key_dir != cur_dir_q) begin
                        push      = 1'b1;
                        push_dir  = key_dir;
                        cur_dir_d = key_dir;
`ifdef FROG_AUTOREPEAT_EN
                        cnt_d     = 8'd0;
                    end else if (cnt_q == DELAY_LAST) begin
                        push    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_REPEAT;
                    end else begin
                        cnt_d = cnt_inc;
`endif
                    end
                end
`ifdef FROG_AUTOREPEAT_EN
                S_REPEAT: begin
                    if (!hit) begin
                        state_d = S_IDLE;
                    end else if (key_dir != cur_dir_q) begin
                        push      = 1'b1;
                        push_dir  = key_dir;
                        cur_dir_d = key_dir;
                        cnt_d     = 8'd0;
                        state_d   = S_HOLD;
                    end else if (cnt_q == PERIOD_LAST) begin
                        push  = 1'b1;
                        cnt_d = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Move FIFO
    // ------------------------------------------------------------------
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          full, pop, push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = move.move_valid & move.move_ready;
    assign push_ok = push & (~full | pop);

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Move storage.
    // NOTE: the storage array has no reset; entries are only observable once written, and pointers are reset.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dir;
        end
    end

    assign move.move_valid = (count_q != '0);
    assign move.move_dir   = move.move_valid ? mem_q[rd_ptr_q] : 2'd0;
    assign queue_count     = count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_frog_move_sequencer.sv
// Self-checking bench for frog_move_sequencer. Frames are generated by the
// bench; a frame-level model (held-frame counting) plus a queue model of the
// FIFO predicts every output on every cycle.
module tb_frog_move_sequencer;

    localparam int DEPTH  = 4;
    localparam int DELAY  = 15;
    localparam int PERIOD = 6;
`ifdef FROG_AUTOREPEAT_EN
    localparam int EXP_HOLD_MOVES = 4;
`else
    localparam int EXP_HOLD_MOVES = 1;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic [2:0]  queue_count;
    logic        overflow;

    frog_move_sequencer_if mif ();

    frog_move_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .move        (mif),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    // Reference model state.
    logic [1:0] q[$];
    logic [1:0] obs[$];
    bit         m_ovf;
    bit         m_held;
    logic [1:0] m_dir;
    int         m_frames;

    function automatic bit key_to_dir(input logic [15:0] k, output logic [1:0] d);
        d = 2'd0;
        case (k[7:0])
            8'h1A:   begin d = 2'd0; return 1'b1; end
            8'h04:   begin d = 2'd1; return 1'b1; end
            8'h16:   begin d = 2'd2; return 1'b1; end
            8'h07:   begin d = 2'd3; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    // Frame-level rule: move on press/direction change, then (with auto-repeat)
    // after DELAY held frames and every PERIOD frames thereafter.
    function automatic bit model_frame(input logic [15:0] k, output logic [1:0] d);
        logic [1:0] kd;
        bit         hit;
        hit = key_to_dir(k, kd);
        d   = kd;
        if (!hit) begin
            m_held = 1'b0;
            return 1'b0;
        end
        if (!m_held || kd != m_dir) begin
            m_held   = 1'b1;
            m_dir    = kd;
            m_frames = 0;
            return 1'b1;
        end
        m_frames++;
        d = m_dir;
`ifdef FROG_AUTOREPEAT_EN
        if (m_frames == DELAY || (m_frames > DELAY && (m_frames - DELAY) % PERIOD == 0))
            return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit rsel(input int mode, input bit at_tick);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            3:       return at_tick;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic void model_clear();
        q.delete();
        m_ovf    = 1'b0;
        m_held   = 1'b0;
        m_dir    = 2'd0;
        m_frames = 0;
    endfunction

    // One clock cycle, entered and left at a falling edge: compare outputs with
    // the model, drive ready, then advance the model across the rising edge.
    task automatic step(input bit tick, input bit rdy);
        logic [1:0] pd;
        bit         psh;
        bit         pp;
        int         sz;
        n_tests++;
        if (mif.move_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_valid t=%0t: got %b want %b", $time, mif.move_valid, q.size() != 0);
        end
        n_tests++;
        if (queue_count !== 3'(q.size())) begin
            n_fail++;
            $display("FAIL sb_count t=%0t: got %0d want %0d", $time, queue_count, q.size());
        end
        n_tests++;
        if (overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL sb_overflow t=%0t: got %b want %b", $time, overflow, m_ovf);
        end
        if (q.size() != 0) begin
            n_tests++;
            if (mif.move_dir !== q[0]) begin
                n_fail++;
                $display("FAIL sb_dir t=%0t: got %0d want %0d", $time, mif.move_dir, q[0]);
            end
        end
        mif.move_ready = rdy;
        if (mif.move_valid === 1'b1 && rdy) begin
            n_pops++;
            obs.push_back(mif.move_dir);
        end
        psh = 1'b0;
        pd  = 2'd0;
        if (tick) psh = model_frame(keycode, pd);
        @(posedge Clk);
        sz = q.size();
        pp = rdy && (sz != 0);
        if (pp) void'(q.pop_front());
        if (psh) begin
            if (sz == DEPTH && !pp) m_ovf = 1'b1;
            else q.push_back(pd);
        end
        @(negedge Clk);
    endtask

    // One video frame: VS rises, the FSM acts on the 3rd Clk edge, VS falls.
    task automatic run_frame(input logic [15:0] key, input int mode);
        keycode   = key;
        frame_clk = 1'b1;
        for (int i = 0; i < 3; i++) step(i == 2, rsel(mode, i == 2));
        frame_clk = 1'b0;
        for (int i = 0; i < int'($urandom_range(3, 6)); i++) step(1'b0, rsel(mode, 1'b0));
    endtask

    task automatic do_reset();
        Reset          = 1'b1;
        frame_clk      = 1'b0;
        keycode        = 16'h0000;
        mif.move_ready = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        model_clear();
        obs.delete();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        n_tests++;
        if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mif.move_valid); end
        n_tests++;
        if (mif.move_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d want 0", mif.move_dir); end
        n_tests++;
        if (queue_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        Reset = 1'b0;
        repeat (4) step(1'b0, 1'b1);
    endtask

    task automatic test_single_press();
        int p0;
        do_reset();
        p0 = n_pops;
        keycode   = 16'h001A;
        frame_clk = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        frame_clk = 1'b0;
        n_tests++;
        if (mif.move_valid !== 1'b1 || mif.move_dir !== 2'd0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b dir=%0d want valid=1 dir=0", mif.move_valid, mif.move_dir);
        end
        repeat (4) step(1'b0, 1'b1);
        run_frame(16'h0000, 1);
        run_frame(16'h0000, 1);
        n_tests++;
        if (n_pops - p0 !== 1) begin n_fail++; $display("FAIL single_moves: got %0d want 1", n_pops - p0); end
        n_tests++;
        if (queue_count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", queue_count); end
    endtask

    task automatic test_hold();
        int p0;
        do_reset();
        p0 = n_pops;
        for (int f = 0; f < 30; f++) run_frame(16'h0007, 1);
        run_frame(16'h0000, 1);
        n_tests++;
        if (n_pops - p0 !== EXP_HOLD_MOVES) begin
            n_fail++;
            $display("FAIL hold_moves: got %0d want %0d", n_pops - p0, EXP_HOLD_MOVES);
        end
        foreach (obs[i]) begin
            n_tests++;
            if (obs[i] !== 2'd3) begin n_fail++; $display("FAIL hold_dir[%0d]: got %0d want 3", i, obs[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] seq [5] = '{16'h0004, 16'h0016, 16'h0007, 16'h001A, 16'h0004};
        logic [1:0]  exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        foreach (seq[i]) run_frame(seq[i], 0);
        n_tests++;
        if (queue_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", queue_count); end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_tests++;
        if (mif.move_dir !== 2'd1) begin n_fail++; $display("FAIL ovf_head: got %0d want 1", mif.move_dir); end
        repeat (3) step(1'b0, 1'b0);
        obs.delete();
        repeat (6) step(1'b0, 1'b1);
        n_tests++;
        if (obs.size() !== 4) begin
            n_fail++;
            $display("FAIL ovf_drain_len: got %0d want 4", obs.size());
        end else begin
            foreach (exp[i]) begin
                n_tests++;
                if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %0d want %0d", i, obs[i], exp[i]); end
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] seq [4] = '{16'h0004, 16'h0016, 16'h0007, 16'h001A};
        do_reset();
        foreach (seq[i]) run_frame(seq[i], 0);
        run_frame(16'h0004, 3);
        n_tests++;
        if (queue_count !== 3'd4) begin n_fail++; $display("FAIL fullpp_count: got %0d want 4", queue_count); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow: got %b want 0", overflow); end
        n_tests++;
        if (mif.move_dir !== 2'd2) begin n_fail++; $display("FAIL fullpp_head: got %0d want 2", mif.move_dir); end
    endtask

    task automatic test_decode();
        do_reset();
        run_frame(16'h1A04, 1);
        run_frame(16'h0029, 1);
        run_frame(16'h0029, 1);
        n_tests++;
        if (obs.size() !== 1) begin
            n_fail++;
            $display("FAIL decode_len: got %0d want 1", obs.size());
        end else begin
            n_tests++;
            if (obs[0] !== 2'd1) begin n_fail++; $display("FAIL decode_dir: got %0d want 1", obs[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int f = 0; f < 22; f++) run_frame(16'h0007, 0);
        Reset = 1'b1;
        @(posedge Clk);
        model_clear();
        @(negedge Clk);
        n_tests++;
        if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", mif.move_valid); end
        n_tests++;
        if (queue_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", queue_count); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        Reset = 1'b0;
        run_frame(16'h0007, 0);
        n_tests++;
        if (queue_count !== 3'd1 || mif.move_dir !== 2'd3) begin
            n_fail++;
            $display("FAIL rstmid_reentry: got count=%0d dir=%0d want count=1 dir=3", queue_count, mif.move_dir);
        end
    endtask

    task automatic test_random();
        logic [7:0]  codes [6] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h00, 8'h29};
        logic [15:0] key;
        int          hold, mode;
        do_reset();
        for (int b = 0; b < 14; b++) begin
            key  = {8'($urandom), codes[$urandom_range(0, 5)]};
            hold = $urandom_range(1, 24);
            mode = $urandom_range(0, 3);
            for (int f = 0; f < hold; f++) run_frame(key, mode);
        end
        repeat (8) step(1'b0, 1'b1);
    endtask

    initial begin
        Reset          = 1'b1;
        frame_clk      = 1'b0;
        keycode        = 16'h0000;
        mif.move_ready = 1'b0;
        model_clear();
        test_reset();
        test_single_press();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_decode();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
